// File: rtl/zx_video_timing.sv
// ZX-class ULA video timing: raster counters, sync/blank, frame interrupt,
// display-memory fetch and the pixel/attribute shifter with border fill.
module zx_video_timing #(
    parameter int HLINE        = 448,
    parameter int VLINE        = 312,
    parameter int HBLANK_START = 320,
    parameter int HBLANK_END   = 415,
    parameter int HSYNC_START  = 344,
    parameter int HSYNC_END    = 375,
    parameter int VSYNC_START  = 248,
    parameter int VSYNC_END    = 251,
    parameter int INT_START    = 2,
    parameter int INT_LEN      = 64,
    parameter int FLASH_BITS   = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic [2:0]  border,
    input  logic        mode,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        i,
    output logic        bi,
    output logic        cn,
    output logic        rd,
    input  logic [7:0]  d,
    output logic [13:0] a,
    output logic [8:0]  hpos,
    output logic [8:0]  vpos
);

    localparam logic [8:0] H_LAST   = 9'(HLINE - 1);
    localparam logic [8:0] V_LAST   = 9'(VLINE - 1);
    localparam logic [8:0] HB_START = 9'(HBLANK_START);
    localparam logic [8:0] HB_END   = 9'(HBLANK_END);
    localparam logic [8:0] HS_START = 9'(HSYNC_START);
    localparam logic [8:0] HS_END   = 9'(HSYNC_END);
    localparam logic [8:0] VS_START = 9'(VSYNC_START);
    localparam logic [8:0] VS_END   = 9'(VSYNC_END);
    localparam logic [8:0] INT_S    = 9'(INT_START);
    localparam logic [8:0] INT_E    = 9'(INT_START + INT_LEN - 1);

    logic [8:0]            hpos_q, hpos_d;
    logic [8:0]            vpos_q, vpos_d;
    logic [FLASH_BITS-1:0] frame_q, frame_d;
    logic                  mode_q, mode_d;
    logic                  video_en_q, video_en_d;
    logic [7:0]            bmp_lat_q, bmp_lat_d;
    logic [7:0]            attr_lat_q, attr_lat_d;
    logic [7:0]            shift_q, shift_d;
    logic [7:0]            attr_q, attr_d;

    logic data_en;
    logic sel;

    assign data_en = (hpos_q <= 9'd255) && (vpos_q <= 9'd191);

    always_comb begin
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        frame_d    = frame_q;
        mode_d     = mode_q;
        video_en_d = video_en_q;
        bmp_lat_d  = bmp_lat_q;
        attr_lat_d = attr_lat_q;
        shift_d    = shift_q;
        attr_d     = attr_q;
        if (ce) begin
            if (hpos_q == H_LAST) begin
                hpos_d = 9'd0;
                if (vpos_q == V_LAST) begin
                    vpos_d  = 9'd0;
                    frame_d = frame_q + FLASH_BITS'(1);
                    mode_d  = mode;
                end else begin
                    vpos_d = vpos_q + 9'd1;
                end
            end else begin
                hpos_d = hpos_q + 9'd1;
            end

            if (hpos_q[3]) begin
                video_en_d = data_en;
            end

            if (data_en) begin
                case (hpos_q[3:0])
                    4'd9, 4'd13:  bmp_lat_d  = d;
                    4'd11, 4'd15: attr_lat_d = d;
                    default: ;
                endcase
            end

            // Outside the display area the paper shows the border colour.
            if (hpos_q[2:0] == 3'd4) begin
                shift_d = video_en_q ? bmp_lat_q : 8'h00;
                attr_d  = video_en_q ? attr_lat_q : {2'b00, border, attr_lat_q[2:0]};
            end else begin
                shift_d = {shift_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hpos_q     <= 9'd0;
            vpos_q     <= 9'd0;
            frame_q    <= '0;
            mode_q     <= 1'b0;
            video_en_q <= 1'b0;
            bmp_lat_q  <= 8'h00;
            attr_lat_q <= 8'h00;
            shift_q    <= 8'h00;
            attr_q     <= 8'h00;
        end else begin
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            frame_q    <= frame_d;
            mode_q     <= mode_d;
            video_en_q <= video_en_d;
            bmp_lat_q  <= bmp_lat_d;
            attr_lat_q <= attr_lat_d;
            shift_q    <= shift_d;
            attr_q     <= attr_d;
        end
    end

    // hpos[1] picks the attribute slot; hi-colour reuses the bitmap layout in bank 1.
    always_comb begin
        if (!hpos_q[1]) begin
            a = {1'b0, vpos_q[7:6], vpos_q[2:0], vpos_q[5:3], hpos_q[7:4], hpos_q[2]};
        end else if (mode_q) begin
            a = {1'b1, vpos_q[7:6], vpos_q[2:0], vpos_q[5:3], hpos_q[7:4], hpos_q[2]};
        end else begin
            a = {1'b0, 3'b110, vpos_q[7:6], vpos_q[5:3], hpos_q[7:4], hpos_q[2]};
        end
    end

    assign rd = hpos_q[3] && data_en;
    assign cn = (hpos_q[3] | hpos_q[2]) && data_en;

    assign blank = ((hpos_q >= HB_START) && (hpos_q <= HB_END)) ||
                   ((vpos_q >= VS_START) && (vpos_q <= 9'd255));
    assign hsync = (hpos_q >= HS_START) && (hpos_q <= HS_END);
    assign vsync = (vpos_q >= VS_START) && (vpos_q <= VS_END);
    assign bi    = !((vpos_q == VS_START) && (hpos_q >= INT_S) && (hpos_q <= INT_E));

    assign sel       = shift_q[7] ^ (frame_q[FLASH_BITS-1] & attr_q[7]);
    assign {g, r, b} = sel ? attr_q[2:0] : attr_q[5:3];
    assign i         = attr_q[6];

    assign hpos = hpos_q;
    assign vpos = vpos_q;

endmodule

// File: tb/tb_zx_video_timing.sv
// Directed bench for zx_video_timing: a compact-raster instance for timing,
// fetch, border and interrupt, plus a tiny-raster instance for flash.
module tb_zx_video_timing;

    localparam int H = 280;
    localparam int V = 210;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b1;
    logic [2:0] border = 3'b010;
    logic mode = 1'b0;
    logic rel = 1'b0;
    logic fl_done = 1'b0;

    logic m_blank, m_hsync, m_vsync, m_r, m_g, m_b, m_i, m_bi, m_cn, m_rd;
    logic [7:0]  m_d;
    logic [13:0] m_a;
    logic [8:0]  m_hpos, m_vpos;

    logic f_blank, f_hsync, f_vsync, f_r, f_g, f_b, f_i, f_bi, f_cn, f_rd;
    logic [7:0]  f_d;
    logic [13:0] f_a;
    logic [8:0]  f_hpos, f_vpos;

    int n_checks = 0;
    int n_fail = 0;
    int ce_cnt = 0;
    int bi_low = 0;

    zx_video_timing #(
        .HLINE(H), .VLINE(V), .HBLANK_START(264), .HBLANK_END(271),
        .HSYNC_START(266), .HSYNC_END(269), .VSYNC_START(204), .VSYNC_END(206),
        .INT_START(2), .INT_LEN(64), .FLASH_BITS(5)
    ) dut (
        .clock(clk), .reset(reset), .ce(ce), .border(border), .mode(mode),
        .blank(m_blank), .hsync(m_hsync), .vsync(m_vsync),
        .r(m_r), .g(m_g), .b(m_b), .i(m_i), .bi(m_bi), .cn(m_cn), .rd(m_rd),
        .d(m_d), .a(m_a), .hpos(m_hpos), .vpos(m_vpos)
    );

    zx_video_timing #(
        .HLINE(64), .VLINE(8), .HBLANK_START(400), .HBLANK_END(401),
        .HSYNC_START(402), .HSYNC_END(403), .VSYNC_START(300), .VSYNC_END(301),
        .INT_START(0), .INT_LEN(1), .FLASH_BITS(5)
    ) dut_flash (
        .clock(clk), .reset(reset), .ce(ce), .border(3'b000), .mode(1'b0),
        .blank(f_blank), .hsync(f_hsync), .vsync(f_vsync),
        .r(f_r), .g(f_g), .b(f_b), .i(f_i), .bi(f_bi), .cn(f_cn), .rd(f_rd),
        .d(f_d), .a(f_a), .hpos(f_hpos), .vpos(f_vpos)
    );

    always #5 clk = ~clk;

    // Video memory: bank 1 attributes 0x38, bank 0 attribute area 0x47, bitmap 0xA5^addr.
    assign m_d = m_a[13] ? 8'h38 : (m_a[11] ? 8'h47 : (8'hA5 ^ m_a[7:0]));
    assign f_d = f_hpos[1] ? 8'h87 : 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (ce) ce_cnt++;
        #1;
        if (!m_bi) bi_low++;
    endtask

    task automatic go_to(input int h, input int v);
        int n = 0;
        while (!(32'(m_hpos) == h && 32'(m_vpos) == v)) begin
            step();
            n++;
            if (n > 70000) begin
                check("goto_timeout", 32'(n), 32'(0));
                return;
            end
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic exp_blank;
        int n;
        pat = 8'hA5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_hpos", 32'(m_hpos), 32'(0));
        check("rst_vpos", 32'(m_vpos), 32'(0));
        check("rst_bi", 32'(m_bi), 32'(1));
        check("rst_rgbi", 32'({m_r, m_g, m_b, m_i}), 32'(0));
        check("rst_sync", 32'({m_hsync, m_vsync, m_blank}), 32'(0));
        reset = 1'b0;
        rel = 1'b1;

        step();
        check("first_ce", 32'(m_hpos), 32'(1));
        ce = 1'b0;
        repeat (4) step();
        check("hold_hpos", 32'(m_hpos), 32'(1));
        check("hold_vpos", 32'(m_vpos), 32'(0));
        ce = 1'b1;

        go_to(4, 0);
        check("cn_h4", 32'(m_cn), 32'(1));
        check("rd_h4", 32'(m_rd), 32'(0));
        go_to(9, 0);
        check("a_std_h9", 32'(m_a), 32'h0000);
        check("rd_h9", 32'(m_rd), 32'(1));
        go_to(11, 0);
        check("a_std_h11", 32'(m_a), 32'h1800);
        go_to(13, 0);
        check("a_std_h13", 32'(m_a), 32'h0001);
        for (int k = 0; k < 8; k++) begin
            check("pix_a5", 32'({m_r, m_g, m_b, m_i}), 32'({pat[7-k], pat[7-k], pat[7-k], 1'b1}));
            if (k == 2) check("a_std_h15", 32'(m_a), 32'h1801);
            step();
        end
        check("pix_a4_b7", 32'({m_r, m_g, m_b, m_i}), 32'(4'b1111));
        step();
        check("pix_a4_b6", 32'({m_r, m_g, m_b, m_i}), 32'(4'b0001));
        go_to(264, 0);
        check("rd_outside", 32'(m_rd), 32'(0));
        check("cn_outside", 32'(m_cn), 32'(0));

        go_to(0, 100);
        mode = 1'b1;
        go_to(9, 101);
        check("a_mid_bmp", 32'(m_a), 32'h0D80);
        go_to(11, 101);
        check("a_mid_attr", 32'(m_a), 32'h1980);

        go_to(0, 200);
        for (int k = 0; k < H; k++) begin
            exp_blank = (k >= 264 && k <= 271);
            check("blank_l200", 32'(m_blank), 32'(exp_blank));
            check("hsync_l200", 32'(m_hsync), 32'(k >= 266 && k <= 269));
            check("vsync_l200", 32'(m_vsync), 32'(0));
            if (!exp_blank) check("border_l200", 32'({m_r, m_g, m_b, m_i}), 32'(4'b1000));
            step();
        end

        go_to(0, 204);
        check("vsync_l204", 32'(m_vsync), 32'(1));
        check("vblank_l204", 32'(m_blank), 32'(1));
        for (int k = 0; k < H; k++) begin
            check("bi_l204", 32'(m_bi), 32'(!(k >= 2 && k <= 65)));
            step();
        end
        go_to(10, 207);
        check("vsync_l207", 32'(m_vsync), 32'(0));
        check("vblank_l207", 32'(m_blank), 32'(1));

        go_to(0, 0);
        check("frame_period", 32'(ce_cnt), 32'(H * V));
        check("bi_low_frame", 32'(bi_low), 32'(64));

        go_to(9, 0);
        check("a_hi_h9", 32'(m_a), 32'h0000);
        go_to(11, 0);
        check("a_hi_h11", 32'(m_a), 32'h2000);
        go_to(13, 0);
        check("a_hi_h13", 32'(m_a), 32'h0001);
        check("pix_hi_ink", 32'({m_r, m_g, m_b, m_i}), 32'(4'b0000));
        step();
        check("pix_hi_paper", 32'({m_r, m_g, m_b, m_i}), 32'(4'b1110));
        go_to(15, 0);
        check("a_hi_h15", 32'(m_a), 32'h2001);

        n = 0;
        while (!fl_done && n < 40000) begin
            @(posedge clk);
            n++;
        end
        check("flash_done", 32'(fl_done), 32'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Flash: attr 0x87 over a blank bitmap is black for frames 0..15, white for 16..31.
    initial begin
        int n;
        wait (rel);
        for (int f = 0; f <= 32; f++) begin
            n = 0;
            while (!(f_hpos == 9'd40 && f_vpos == 9'd2) && n <= 2000) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n > 2000) check("flash_timeout", 32'(n), 32'(0));
            check("flash_rgbi", 32'({f_r, f_g, f_b, f_i}), ((f % 32) < 16) ? 32'(4'b0000) : 32'(4'b1110));
            @(posedge clk);
            #1;
        end
        fl_done = 1'b1;
    end

endmodule

// File: doc/zx_video_timing.md
Name: zx_video_timing

Overview:
- Parametrised ZX-class ULA video generator: raster counters, sync/blank, frame interrupt, display-memory fetch, pixel/attribute shifter and border.
- Timing is set by parameters, so one block covers 48K (448x312) and 128K (456x311) machines.
- Runtime mode selects standard attributes (one attribute per 8x8 cell) or Timex-style hi-colour (one attribute per 8x1 row from the second screen half).
- Sits between the video RAM arbiter (a/d/rd/cn) and the scan-doubler/RGBI encoder.

Parameters:
HLINE, 448, pixel clocks per line (count 0..HLINE-1)
VLINE, 312, lines per frame (count 0..VLINE-1)
HBLANK_START, 320, first blanked column
HBLANK_END, 415, last blanked column
HSYNC_START, 344, first hsync column
HSYNC_END, 375, last hsync column
VSYNC_START, 248, first vsync/vblank line
VSYNC_END, 251, last vsync line (vblank runs to 255)
INT_START, 2, first column of interrupt pulse on line VSYNC_START
INT_LEN, 64, interrupt pulse length in pixel clocks
FLASH_BITS, 5, frame-counter width; MSB is the flash phase

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ce  in  1  pixel clock enable; all state advances only when ce=1
border  in  3  border colour GRB
mode  in  1  0=standard, 1=hi-colour; sampled at frame start only
blank  out  1  hblank | vblank
hsync  out  1  horizontal sync, active-high
vsync  out  1  vertical sync, active-high
r,g,b,i  out  1 each  pixel colour and bright
bi  out  1  frame interrupt, active-low
cn  out  1  contention window
rd  out  1  video memory read strobe
d  in  8  video memory read data
a  out  14  video memory address; bit13 selects hi-colour attribute bank
hpos  out  9  current column
vpos  out  9  current line

Behaviour:
- Reset (reset=1 on a clock edge, regardless of ce): hpos=vpos=0, frame counter=0, latched mode=0, shifters=0, videoEnable=0.
- Outputs after reset: r=g=b=i=0, bi=1, hsync=vsync=blank=0.
- hpos wraps HLINE-1->0. vpos increments on each hpos wrap; vpos wraps VLINE-1->0. The frame counter increments on each vpos wrap and wraps modulo 2^FLASH_BITS.
- Mode latch: mode is sampled when ce=1 and hpos=HLINE-1 and vpos=VLINE-1. The new value applies from line 0 of the next frame. A change mid-frame has no visible effect until then.
- dataEnable = hpos<=255 && vpos<=191. videoEnable is loaded with dataEnable on every ce while hpos[3]=1.
- Fetch, per 16-column group, only while dataEnable:
  - hpos[3:0]=9 and 13: bitmap byte latched from d.
  - hpos[3:0]=11 and 15: attribute byte latched from d.
- Address a: 13 low bits are column/row fields; bit13 is the bank.
  - hpos[1]=0 (bitmap): {0, v[7:6], v[2:0], v[5:3], h[7:4], h[2]}.
  - hpos[1]=1, standard mode: {0, 3'b110, v[7:6], v[5:3], h[7:4], h[2]}.
  - hpos[1]=1, hi-colour mode: bitmap address with bit13=1.
- rd = hpos[3] && dataEnable. cn = |hpos[3:2] && dataEnable.
- Output shifter: at hpos[2:0]=4, load the bitmap latch if videoEnable, else load 0. At every other ce, shift left and fill with 0.
- Attribute register: loaded at hpos[2:0]=4.
  - If videoEnable: takes the attribute latch.
  - Otherwise: {flash=0, bright=0, paper=border, ink=attr latch[2:0]}.
- Pixel colour:
  - sel = shifter[7] ^ (frameCounter[MSB] & attr[7]).
  - sel=1 gives ink (attr[2:0], GRB); sel=0 gives paper (attr[5:3]).
  - i = attr[6].
  - Resulting latency: a byte fetched at column N appears on r/g/b from the next hpos[2:0]=4 boundary, 8 pixels per byte.
- Blanking and sync:
  - hblank: HBLANK_START<=hpos<=HBLANK_END.
  - vblank: VSYNC_START<=vpos<=255.
  - hsync: HSYNC_START<=hpos<=HSYNC_END.
  - vsync: VSYNC_START<=vpos<=VSYNC_END.
  - All of these are combinational from the counters.
- bi=0 iff vpos=VSYNC_START and INT_START<=hpos<=INT_START+INT_LEN-1.
- ce=0 holds every register. Combinational outputs remain stable because the counters do not change.

Test Plan:
- Reset held 3 clocks with ce=1, then released:
  - hpos=vpos=0, bi=1, r=g=b=i=0.
  - First ce advances hpos to 1.
- Free-run with ce=1:
  - Exactly HLINE*VLINE=139776 ce cycles between successive vpos=0,hpos=0 events.
  - With HLINE=456, VLINE=311 the count is 141816.
- Interrupt window:
  - On line 248, bi is low for exactly 64 ce cycles, hpos=2..65.
  - No other bi pulse in the frame.
- Address sequence on line 0, hpos 8..15, standard mode: a = 0x0000, 0x1800, 0x0001, 0x1801 at hpos 9, 11, 13, 15.
- Same point in hi-colour mode: a = 0x0000, 0x2000, 0x0001, 0x2001.
- mode toggled 0->1 at vpos=100: addresses stay standard until the frame wraps, then switch to hi-colour from vpos=0.
- Border 3'b010 with vpos=200:
  - r=1, g=0, b=0 for all non-blanked columns.
- Flash:
  - With bitmap=0x00, attr=0x87, output is paper (black) for 16 frames.
  - For the next 16 frames the output is ink (white), r=g=b=1.
